router_fsm: RTL and testbench
=============================

# router_fsm

Control FSM for the 1x3 router. Sequences the register stage (Router_Register) and the three output FIFOs: decodes the destination of each incoming packet, waits for the addressed FIFO to drain, and steps the register through header, payload, full-stall, after-full and parity loads. The block sits between the input port and the register/synchronizer. It is the only source of the register's control strobes.

## Interface
- Parameters: none.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- pkt_valid  in  1  packet byte on data_in is valid; deasserts on the parity byte
- data_in  in  2  destination address bits [1:0] of the header byte (0,1,2 valid; 3 invalid)
- fifo_full  in  1  addressed FIFO full (from synchronizer)
- fifo_empty_0/1/2  in  1 each  FIFO n empty
- soft_reset_0/1/2  in  1 each  FIFO n timed-out soft reset
- parity_done  in  1  register has captured the parity byte
- low_pkt_valid  in  1  register saw pkt_valid fall while stalled
- detect_addr, lfd_state, ld_state, full_state, laf_state, rst_int_reg  out  1 each  register control strobes
- write_enb_reg  out  1  write enable toward the FIFOs
- busy  out  1  input port must hold data

## Operation
- Moore FSM, 8 states, one registered state vector, 2-bit registered addr_q.
- DECODE_ADDRESS (DA), reset state:
  - pkt_valid & data_in!=3 & fifo_empty[data_in] -> LFD.
  - pkt_valid & data_in!=3 & !fifo_empty[data_in] -> WTE.
  - Otherwise stay. data_in==3 packets are ignored.
  - addr_q <= data_in whenever DA & pkt_valid.
- LOAD_FIRST_DATA (LFD) -> LD unconditionally.
- LOAD_DATA (LD):
  - fifo_full -> FFS.
  - else !pkt_valid -> LP.
  - else stay.
- FIFO_FULL_STATE (FFS): fifo_full stay; else -> LAF.
- LOAD_AFTER_FULL (LAF):
  - parity_done -> DA.
  - else low_pkt_valid -> LP.
  - else -> LD.
- LOAD_PARITY (LP) -> CPE unconditionally.
- CHECK_PARITY_ERROR (CPE): fifo_full -> FFS; else -> DA.
- WAIT_TILL_EMPTY (WTE): fifo_empty[addr_q] -> LFD; else stay.
- Soft reset: soft_reset[addr_q]=1 in any state other than DA forces next state DA. This has highest priority. In DA soft resets are ignored.
- Output decode:
  - detect_addr=DA, lfd_state=LFD, ld_state=LD, full_state=FFS, laf_state=LAF, rst_int_reg=CPE.
  - write_enb_reg = LD|LP|LAF.
  - busy = LFD|FFS|LAF|LP|CPE|WTE (0 only in DA and LD).

## Timing
- Reset (async assert, sync-safe release): state=DA, addr_q=0. detect_addr=1; every other output 0; busy=0.
- All outputs are pure functions of the registered state, with no combinational input-to-output path. Strobes change one clk after the causing input is sampled.
- Clean packet, empty FIFO, never full, payload N bytes, header sampled at edge k:
  - LFD in cycle k+1.
  - LD for cycles k+2..k+N+2; pkt_valid low on the parity byte is sampled at the last LD edge.
  - LP one cycle, CPE one cycle, then DA.
- fifo_full and pkt_valid falling in the same LD cycle: fifo_full wins (-> FFS). The parity path then resolves via LAF using low_pkt_valid/parity_done.
- parity_done and low_pkt_valid both high in LAF: parity_done wins (-> DA).
- Reset asserted mid-packet: state returns to DA immediately, with no completion of the parity sequence.
- WTE has no timeout inside this block; exit is by empty or soft_reset only.

## Test plan
- Reset: assert reset mid-cycle -> detect_addr=1, busy=0, write_enb_reg=0 immediately; addr_q=0.
- Header 0x22 (addr 2, len 8), fifo_empty_2=1, no full -> one cycle lfd_state, 9 cycles ld_state, then LP (write_enb_reg=1, busy=1), one cycle rst_int_reg, back to detect_addr.
- Header addr 1, fifo_empty_1=0 for 5 cycles then 1 -> WTE with busy=1 for those cycles, then LFD next edge.
- fifo_full=1 for 3 cycles during LD -> full_state=1 for 3 cycles, write_enb_reg=0. Then LAF one cycle. With low_pkt_valid=1 -> LP; with parity_done=1 -> DA.
- soft_reset_0=1 while in FFS for addr 0 -> DA next edge. soft_reset_1 pulse with addr_q=0 -> no effect.
- Header with data_in=3 and pkt_valid=1 -> remain in DA, no strobes, addr_q updated to 3 but no transition.

Source files
------------

// File: rtl/router_fsm_if.sv
// Control/strobe bundle between the router input side, the synchronizer,
// the register stage and the router control FSM.
interface router_fsm_if;
  logic       pkt_valid;
  logic [1:0] data_in;
  logic       fifo_full;
  logic       fifo_empty_0;
  logic       fifo_empty_1;
  logic       fifo_empty_2;
  logic       soft_reset_0;
  logic       soft_reset_1;
  logic       soft_reset_2;
  logic       parity_done;
  logic       low_pkt_valid;

  logic       detect_addr;
  logic       lfd_state;
  logic       ld_state;
  logic       full_state;
  logic       laf_state;
  logic       rst_int_reg;
  logic       write_enb_reg;
  logic       busy;

  // Side that drives packet/FIFO status and observes the strobes.
  modport master (
    output pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    input  detect_addr, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy
  );

  // Side implemented by the control FSM.
  modport slave (
    input  pkt_valid, data_in, fifo_full,
           fifo_empty_0, fifo_empty_1, fifo_empty_2,
           soft_reset_0, soft_reset_1, soft_reset_2,
           parity_done, low_pkt_valid,
    output detect_addr, lfd_state, ld_state, full_state, laf_state,
           rst_int_reg, write_enb_reg, busy
  );
endinterface

// File: rtl/router_fsm.sv
// Router 1x3 control FSM: decodes the packet destination, waits for the
// addressed FIFO to drain and sequences the register stage strobes.
// Moore machine: every output decodes from the registered state only.
module router_fsm (
  input  logic          clk,
  input  logic          reset,
  router_fsm_if.slave   bus
);

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    FIFO_FULL_STATE,
    LOAD_AFTER_FULL,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    WAIT_TILL_EMPTY
  } state_t;

  state_t     r_state;
  state_t     w_next;
  logic [1:0] r_addr_q;
  logic       w_empty_in;    // empty flag of FIFO addressed by data_in
  logic       w_empty_addr;  // empty flag of FIFO latched in r_addr_q
  logic       w_soft_addr;   // soft reset of FIFO latched in r_addr_q

  // Select per-FIFO status; address 3 maps to "not empty / no soft reset".
  always_comb begin
    w_empty_in   = 1'b0;
    w_empty_addr = 1'b0;
    w_soft_addr  = 1'b0;
    case (bus.data_in)
      2'd0:    w_empty_in = bus.fifo_empty_0;
      2'd1:    w_empty_in = bus.fifo_empty_1;
      2'd2:    w_empty_in = bus.fifo_empty_2;
      default: w_empty_in = 1'b0;
    endcase
    case (r_addr_q)
      2'd0: begin
        w_empty_addr = bus.fifo_empty_0;
        w_soft_addr  = bus.soft_reset_0;
      end
      2'd1: begin
        w_empty_addr = bus.fifo_empty_1;
        w_soft_addr  = bus.soft_reset_1;
      end
      2'd2: begin
        w_empty_addr = bus.fifo_empty_2;
        w_soft_addr  = bus.soft_reset_2;
      end
      default: begin
        w_empty_addr = 1'b0;
        w_soft_addr  = 1'b0;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= DECODE_ADDRESS;
    else       r_state <= w_next;
  end

  // Destination latch: follows data_in whenever a valid byte is seen in decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_addr_q <= '0;
    else if (r_state == DECODE_ADDRESS && bus.pkt_valid)
      r_addr_q <= bus.data_in;
  end

  // Next-state logic; soft reset of the addressed FIFO overrides everything
  // except in decode, where no FIFO is owned yet.
  always_comb begin
    w_next = r_state;
    case (r_state)
      DECODE_ADDRESS: begin
        if (bus.pkt_valid && bus.data_in != 2'd3)
          w_next = w_empty_in ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
      end
      LOAD_FIRST_DATA: w_next = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       w_next = FIFO_FULL_STATE;
        else if (!bus.pkt_valid) w_next = LOAD_PARITY;
      end
      FIFO_FULL_STATE: begin
        if (!bus.fifo_full) w_next = LOAD_AFTER_FULL;
      end
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        w_next = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) w_next = LOAD_PARITY;
        else                        w_next = LOAD_DATA;
      end
      LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: begin
        w_next = bus.fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
      end
      WAIT_TILL_EMPTY: begin
        if (w_empty_addr) w_next = LOAD_FIRST_DATA;
      end
      default: w_next = DECODE_ADDRESS;
    endcase
    if (r_state != DECODE_ADDRESS && w_soft_addr)
      w_next = DECODE_ADDRESS;
  end

  // Output decode from registered state.
  always_comb begin
    bus.detect_addr   = (r_state == DECODE_ADDRESS);
    bus.lfd_state     = (r_state == LOAD_FIRST_DATA);
    bus.ld_state      = (r_state == LOAD_DATA);
    bus.full_state    = (r_state == FIFO_FULL_STATE);
    bus.laf_state     = (r_state == LOAD_AFTER_FULL);
    bus.rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
    bus.write_enb_reg = (r_state == LOAD_DATA) || (r_state == LOAD_PARITY) ||
                        (r_state == LOAD_AFTER_FULL);
    bus.busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
  end

endmodule

// File: tb/tb_router_fsm.sv
// Bench for router_fsm: directed packet scenarios; the expected state after
// each clock edge is pushed to a scoreboard and compared after the edge.
module tb_router_fsm;

  typedef enum int {S_DA, S_LFD, S_LD, S_FFS, S_LAF, S_LP, S_CPE, S_WTE} exp_st_t;

  typedef struct {
    string      tag;
    logic [7:0] v;
  } sb_item_t;

  logic clk;
  logic reset;
  router_fsm_if bus ();

  router_fsm dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  sb_item_t    sb[$];

  // {detect, lfd, ld, full, laf, rst_int, write_enb, busy}
  function automatic logic [7:0] exp_outs(input exp_st_t s);
    case (s)
      S_DA:    return 8'b1000_0000;
      S_LFD:   return 8'b0100_0001;
      S_LD:    return 8'b0010_0010;
      S_FFS:   return 8'b0001_0001;
      S_LAF:   return 8'b0000_1011;
      S_LP:    return 8'b0000_0011;
      S_CPE:   return 8'b0000_0101;
      S_WTE:   return 8'b0000_0001;
      default: return 8'b0000_0000;
    endcase
  endfunction

  function automatic logic [7:0] obs();
    return {bus.detect_addr, bus.lfd_state, bus.ld_state, bus.full_state,
            bus.laf_state, bus.rst_int_reg, bus.write_enb_reg, bus.busy};
  endfunction

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b (det,lfd,ld,full,laf,rst,wen,busy) t=%0t",
               tag, got, exp, $time);
    end
  endtask

  // Push the state expected after the next edge, clock, then pop and compare.
  task automatic tick(input exp_st_t e, input string tag);
    sb_item_t it;
    sb.push_back('{tag, exp_outs(e)});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      it = sb.pop_front();
      check_val(it.tag, obs(), it.v);
    end
  endtask

  initial begin
    reset             = 1'b1;
    bus.pkt_valid     = 1'b0;
    bus.data_in       = 2'd0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty_0  = 1'b1;
    bus.fifo_empty_1  = 1'b1;
    bus.fifo_empty_2  = 1'b1;
    bus.soft_reset_0  = 1'b0;
    bus.soft_reset_1  = 1'b0;
    bus.soft_reset_2  = 1'b0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;

    #3;
    check_val("reset_state", obs(), exp_outs(S_DA));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // Clean packet to FIFO 2, 8 payload bytes.
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
    tick(S_LFD, "a_lfd");
    bus.data_in = 2'd0;
    tick(S_LD, "a_ld0");
    for (int unsigned i = 0; i < 8; i++) tick(S_LD, "a_ld");
    bus.pkt_valid = 1'b0;
    tick(S_LP, "a_lp");
    tick(S_CPE, "a_cpe");
    tick(S_DA, "a_da");
    tick(S_DA, "a_idle");

    // FIFO 1 busy for 5 cycles.
    bus.fifo_empty_1 = 1'b0;
    bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    tick(S_WTE, "b_wte0");
    bus.pkt_valid = 1'b0;
    for (int unsigned i = 0; i < 4; i++) tick(S_WTE, "b_wte");
    bus.fifo_empty_1 = 1'b1;
    tick(S_LFD, "b_lfd");
    bus.pkt_valid = 1'b1;
    tick(S_LD, "b_ld");
    bus.pkt_valid = 1'b0;
    tick(S_LP, "b_lp");
    tick(S_CPE, "b_cpe");
    tick(S_DA, "b_da");

    // Full for 3 cycles, then LAF -> LP via low_pkt_valid.
    bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    tick(S_LFD, "c_lfd");
    tick(S_LD, "c_ld");
    tick(S_LD, "c_ld");
    bus.fifo_full = 1'b1;
    for (int unsigned i = 0; i < 3; i++) tick(S_FFS, "c_ffs");
    bus.fifo_full = 1'b0;
    tick(S_LAF, "c_laf");
    bus.pkt_valid = 1'b0; bus.low_pkt_valid = 1'b1;
    tick(S_LP, "c_lp");
    bus.low_pkt_valid = 1'b0;
    tick(S_CPE, "c_cpe");
    tick(S_DA, "c_da");

    // Full and pkt_valid fall together; LAF with parity_done beating low_pkt_valid.
    bus.pkt_valid = 1'b1;
    tick(S_LFD, "d_lfd");
    tick(S_LD, "d_ld");
    bus.fifo_full = 1'b1; bus.pkt_valid = 1'b0;
    tick(S_FFS, "d_full_wins");
    bus.fifo_full = 1'b0;
    tick(S_LAF, "d_laf");
    bus.parity_done = 1'b1; bus.low_pkt_valid = 1'b1;
    tick(S_DA, "d_pdone_wins");
    bus.parity_done = 1'b0; bus.low_pkt_valid = 1'b0;
    tick(S_DA, "d_idle");

    // LAF -> LD, CPE -> FFS on full, soft reset 0 in FFS.
    bus.pkt_valid = 1'b1;
    tick(S_LFD, "e_lfd");
    tick(S_LD, "e_ld");
    bus.fifo_full = 1'b1;
    tick(S_FFS, "e_ffs");
    bus.fifo_full = 1'b0;
    tick(S_LAF, "e_laf");
    tick(S_LD, "e_laf_ld");
    bus.pkt_valid = 1'b0;
    tick(S_LP, "e_lp");
    bus.fifo_full = 1'b1;
    tick(S_CPE, "e_cpe");
    tick(S_FFS, "e_cpe_ffs");
    bus.soft_reset_0 = 1'b1;
    tick(S_DA, "e_soft0_ffs");
    bus.soft_reset_0 = 1'b0; bus.fifo_full = 1'b0;

    // Soft reset of another FIFO ignored; soft reset ignored in DA.
    bus.soft_reset_0 = 1'b1; bus.pkt_valid = 1'b1; bus.data_in = 2'd0;
    tick(S_LFD, "f_soft_in_da");
    bus.soft_reset_0 = 1'b0; bus.soft_reset_1 = 1'b1;
    tick(S_LD, "f_soft1_other");
    tick(S_LD, "f_soft1_other");
    bus.soft_reset_1 = 1'b0; bus.pkt_valid = 1'b0;
    tick(S_LP, "f_lp");
    tick(S_CPE, "f_cpe");
    tick(S_DA, "f_da");

    // WTE exits on soft reset of the awaited FIFO.
    bus.fifo_empty_1 = 1'b0; bus.pkt_valid = 1'b1; bus.data_in = 2'd1;
    tick(S_WTE, "g_wte");
    bus.pkt_valid = 1'b0;
    tick(S_WTE, "g_wte");
    bus.soft_reset_1 = 1'b1;
    tick(S_DA, "g_soft1_wte");
    bus.soft_reset_1 = 1'b0; bus.fifo_empty_1 = 1'b1;

    // Invalid address 3 is ignored.
    bus.pkt_valid = 1'b1; bus.data_in = 2'd3;
    tick(S_DA, "h_addr3");
    tick(S_DA, "h_addr3");
    bus.pkt_valid = 1'b0;
    tick(S_DA, "h_idle");

    // Asynchronous reset mid-packet.
    bus.pkt_valid = 1'b1; bus.data_in = 2'd2;
    tick(S_LFD, "i_lfd");
    tick(S_LD, "i_ld");
    #2;
    reset = 1'b1;
    #1;
    check_val("async_reset", obs(), exp_outs(S_DA));
    #1;
    reset = 1'b0;
    bus.pkt_valid = 1'b0;
    tick(S_DA, "i_after_rst");

    if (sb.size() != 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
